data_cache: RTL

Direct-mapped, write-back, write-allocate data cache between the processor's load/store path and the multi-cycle data memory. It serves hits with no wait states. On a miss it stalls the CPU through `cpu_busywait`, writes back a dirty victim block if needed, fetches the whole 4-byte block from memory, then completes the access as a hit.

---
 rtl/cache_pkg.sv | 29 ++
 rtl/cache_ctrl.sv | 64 ++++++
 rtl/data_cache.sv | 94 +++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// Shared geometry, FSM state type and address field helpers for the data cache.
package cache_pkg;

  localparam int CPU_ADDR_W = 8;
  localparam int TAG_W      = 3;
  localparam int INDEX_W    = 3;
  localparam int OFFSET_W   = 2;
  localparam int BLOCK_W    = 32;
  localparam int MEM_ADDR_W = TAG_W + INDEX_W;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } cache_state_e;

  function automatic logic [TAG_W-1:0] addr_tag(input logic [CPU_ADDR_W-1:0] a);
    return a[CPU_ADDR_W-1 -: TAG_W];
  endfunction

  function automatic logic [INDEX_W-1:0] addr_index(input logic [CPU_ADDR_W-1:0] a);
    return a[OFFSET_W +: INDEX_W];
  endfunction

  function automatic logic [OFFSET_W-1:0] addr_offset(input logic [CPU_ADDR_W-1:0] a);
    return a[OFFSET_W-1:0];
  endfunction

endpackage

// File: rtl/cache_ctrl.sv
// Miss-handling FSM: writes back a dirty victim, then fetches the new block.
module cache_ctrl
  import cache_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_i,
  input  logic                  hit_i,
  input  logic                  victim_dirty_i,
  input  logic [TAG_W-1:0]      old_tag_i,
  input  logic [TAG_W-1:0]      new_tag_i,
  input  logic [INDEX_W-1:0]    index_i,
  input  logic [BLOCK_W-1:0]    line_i,
  input  logic                  mem_busywait_i,
  output logic                  mem_read_o,
  output logic                  mem_write_o,
  output logic [MEM_ADDR_W-1:0] mem_address_o,
  output logic [BLOCK_W-1:0]    mem_writedata_o,
  output logic                  fill_o,
  output cache_state_e          state_o
);

  cache_state_e state_q, state_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // A transfer completes on any edge where the request is up and memory is not busy.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (req_i && !hit_i) state_d = victim_dirty_i ? WRITEBACK : ALLOCATE;
      WRITEBACK: if (!mem_busywait_i) state_d = ALLOCATE;
      ALLOCATE:  if (!mem_busywait_i) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_read_o      = 1'b0;
    mem_write_o     = 1'b0;
    mem_address_o   = '0;
    mem_writedata_o = '0;
    fill_o          = 1'b0;
    case (state_q)
      WRITEBACK: begin
        mem_write_o     = 1'b1;
        mem_address_o   = {old_tag_i, index_i};
        mem_writedata_o = line_i;
      end
      ALLOCATE: begin
        mem_read_o    = 1'b1;
        mem_address_o = {new_tag_i, index_i};
        fill_o        = !mem_busywait_i;
      end
      default: ;
    endcase
  end

  assign state_o = state_q;

endmodule

// File: rtl/data_cache.sv
// Direct-mapped write-back, write-allocate data cache; line arrays and hit logic live here.
module data_cache
  import cache_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int NUM_BLOCKS  = 8,
  parameter int BLOCK_BYTES = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           cpu_read,
  input  logic                           cpu_write,
  input  logic [ADDR_W-1:0]              cpu_address,
  input  logic [DATA_W-1:0]              cpu_writedata,
  output logic [DATA_W-1:0]              cpu_readdata,
  output logic                           cpu_busywait,
  output logic                           mem_read,
  output logic                           mem_write,
  output logic [MEM_ADDR_W-1:0]          mem_address,
  output logic [BLOCK_BYTES*DATA_W-1:0]  mem_writedata,
  input  logic [BLOCK_BYTES*DATA_W-1:0]  mem_readdata,
  input  logic                           mem_busywait
);

  localparam int LINE_W = BLOCK_BYTES * DATA_W;

  logic [NUM_BLOCKS-1:0] valid_q;
  logic [NUM_BLOCKS-1:0] dirty_q;
  logic [TAG_W-1:0]      tag_q  [NUM_BLOCKS];
  logic [LINE_W-1:0]     data_q [NUM_BLOCKS];

  logic [TAG_W-1:0]    req_tag;
  logic [INDEX_W-1:0]  idx;
  logic [OFFSET_W-1:0] off;
  logic [LINE_W-1:0]   line;
  logic                hit;
  logic                req;
  logic                write_hit;
  logic                fill;
  cache_state_e        state;

  assign req_tag = addr_tag(cpu_address);
  assign idx     = addr_index(cpu_address);
  assign off     = addr_offset(cpu_address);
  assign line    = data_q[idx];
  assign hit     = valid_q[idx] && (tag_q[idx] == req_tag);

  // Read and write together is treated as no request at all.
  assign req          = cpu_read ^ cpu_write;
  assign cpu_busywait = req && !(state == IDLE && hit);
  assign write_hit    = cpu_write && !cpu_read && state == IDLE && hit;
  assign cpu_readdata = line[{off, 3'b000} +: DATA_W];

  cache_ctrl u_ctrl (
    .clk             (clk),
    .rst             (rst),
    .req_i           (req),
    .hit_i           (hit),
    .victim_dirty_i  (valid_q[idx] && dirty_q[idx]),
    .old_tag_i       (tag_q[idx]),
    .new_tag_i       (req_tag),
    .index_i         (idx),
    .line_i          (line),
    .mem_busywait_i  (mem_busywait),
    .mem_read_o      (mem_read),
    .mem_write_o     (mem_write),
    .mem_address_o   (mem_address),
    .mem_writedata_o (mem_writedata),
    .fill_o          (fill),
    .state_o         (state)
  );

  // A fill lands clean; the pending store then hits in IDLE and marks the line dirty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
      for (int i = 0; i < NUM_BLOCKS; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else if (fill) begin
      data_q[idx]  <= mem_readdata;
      tag_q[idx]   <= req_tag;
      valid_q[idx] <= 1'b1;
      dirty_q[idx] <= 1'b0;
    end else if (write_hit) begin
      data_q[idx][{off, 3'b000} +: DATA_W] <= cpu_writedata;
      dirty_q[idx] <= 1'b1;
    end
  end

endmodule
